// File: rtl/pwm_modulator.sv
// Edge-aligned PWM modulator: samples a signed waveform once per period and
// drives a complementary half-bridge gate pair with programmable dead-time.
module pwm_modulator #(
    parameter int CNT_W    = 10,
    parameter int DEADTIME = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [15:0]      sample_in,
    output logic             pwm_hi,
    output logic             pwm_lo,
    output logic             period_start,
    output logic [CNT_W-1:0] duty_out
);

    typedef enum logic [1:0] {
        IDLE,
        DEAD,
        HIGH,
        LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] DUTY_MID  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [7:0]       DEAD_LOAD = 8'(DEADTIME);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] duty_reg;
    logic [CNT_W-1:0] duty_next;
    logic [15:0]      offset;
    logic             wrap;
    logic             raw;
    logic [7:0]       dead_cnt;
    logic             dead_load;
    logic             dead_done;
    state_t           state;
    state_t           state_next;

    // Offset-binary conversion, then keep the top CNT_W bits (truncation).
    assign offset    = {~sample_in[15], sample_in[14:0]};
    assign duty_next = CNT_W'(offset >> (16 - CNT_W));

    assign wrap      = enable && (cnt == CNT_MAX);
    assign raw       = (cnt < duty_reg);
    assign dead_done = (dead_cnt <= 8'd1);
    assign duty_out  = duty_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_reg     <= DUTY_MID;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
            if (wrap) begin
                duty_reg <= duty_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The dead counter counts down from DEADTIME; the final DEAD cycle is the one at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            dead_cnt <= '0;
        end else if (!enable) begin
            dead_cnt <= '0;
        end else if (dead_load) begin
            dead_cnt <= DEAD_LOAD;
        end else if ((state == DEAD) && (dead_cnt != 8'd0)) begin
            dead_cnt <= dead_cnt - 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        dead_load  = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    state_next = DEAD;
                    dead_load  = 1'b1;
                end
                DEAD: begin
                    if (dead_done) begin
                        state_next = raw ? HIGH : LOW;
                    end
                end
                HIGH: begin
                    if (!raw) begin
                        state_next = DEAD;
                        dead_load  = 1'b1;
                    end
                end
                LOW: begin
                    if (raw) begin
                        state_next = DEAD;
                        dead_load  = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Gate drives are decoded from the next state so they are true registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            pwm_hi <= (state_next == HIGH);
            pwm_lo <= (state_next == LOW);
        end
    end

endmodule

// File: tb/tb_pwm_modulator.sv
// Self-checking bench for pwm_modulator (CNT_W=8, DEADTIME=4) against a
// period-level reference model of the expected gate pattern.
module tb_pwm_modulator;

    localparam int CW = 8;
    localparam int DT = 4;
    localparam int N  = 1 << CW;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [15:0]   sample_in;
    logic          pwm_hi;
    logic          pwm_lo;
    logic          period_start;
    logic [CW-1:0] duty_out;

    pwm_modulator #(
        .CNT_W    (CW),
        .DEADTIME (DT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_in    (sample_in),
        .pwm_hi       (pwm_hi),
        .pwm_lo       (pwm_lo),
        .period_start (period_start),
        .duty_out     (duty_out)
    );

    always #5 clk = ~clk;

    int   compared   = 0;
    int   mismatched = 0;

    // Reference model state
    int   cnt_m  = 0;
    int   duty_m = N / 2;
    int   age    = 0;
    logic ps_m   = 1'b0;
    bit   gates_known = 1'b0;
    logic exp_hi = 1'b0;
    logic exp_lo = 1'b0;
    int   hi_acc = 0;
    int   lo_acc = 0;
    int   acc_duty = 0;
    bit   acc_valid = 1'b0;

    function automatic int duty_of(input logic [15:0] s);
        return (int'($signed(s)) + 32768) / (65536 / N);
    endfunction

    function automatic logic [15:0] sample_for(input int d);
        int u;
        u = d * (65536 / N) + int'($urandom_range(0, (65536 / N) - 1));
        return 16'(u ^ 32'h8000);
    endfunction

    // Steady-state gate levels at counter value c for duty d; p counts cycles
    // since the raw rising edge reached the gates (one cycle of latency).
    task automatic expected_gates(input int d, input int c, output logic hi, output logic lo);
        int p;
        p  = (c + N - 1) % N;
        hi = 1'b0;
        lo = 1'b0;
        if (d == 0) begin
            lo = 1'b1;
        end else if (d <= DT) begin
            lo = (p >= DT);
        end else if (N - d <= DT) begin
            hi = !(((p - d + N) % N) < DT);
        end else begin
            hi = (p >= DT) && (p <= d - 1);
            lo = (p >= d + DT);
        end
    endtask

    task automatic expected_counts(input int d, output int hi, output int lo);
        if (d == 0) begin
            hi = 0;
            lo = N;
        end else if (d <= DT) begin
            hi = 0;
            lo = N - DT;
        end else if (N - d <= DT) begin
            hi = N - DT;
            lo = 0;
        end else begin
            hi = d - DT;
            lo = N - d - DT;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic observe(input logic rst_b, input logic en_b);
        int eh;
        int el;
        check("duty_out", 32'(duty_out), 32'(duty_m));
        check("period_start", 32'(period_start), 32'(ps_m));
        check("gate_overlap", 32'(pwm_hi & pwm_lo), 32'd0);
        if (gates_known) begin
            check("pwm_hi", 32'(pwm_hi), 32'(exp_hi));
            check("pwm_lo", 32'(pwm_lo), 32'(exp_lo));
        end
        if (!rst_b && en_b) begin
            if (cnt_m == 0) begin
                if (acc_valid) begin
                    expected_counts(acc_duty, eh, el);
                    check("hi_per_period", 32'(hi_acc), 32'(eh));
                    check("lo_per_period", 32'(lo_acc), 32'(el));
                end
                acc_valid = (age >= 2);
                acc_duty  = duty_m;
                hi_acc    = 0;
                lo_acc    = 0;
            end
            hi_acc += int'(pwm_hi);
            lo_acc += int'(pwm_lo);
        end
    endtask

    task automatic tick();
        logic        en_b;
        logic        rst_b;
        logic [15:0] s_b;
        int          cnt_b;
        int          nd;
        en_b  = enable;
        rst_b = reset;
        s_b   = sample_in;
        cnt_b = cnt_m;
        @(posedge clk);
        if (rst_b) begin
            cnt_m = 0; duty_m = N / 2; ps_m = 1'b0; age = 0; acc_valid = 1'b0;
            gates_known = 1'b1; exp_hi = 1'b0; exp_lo = 1'b0;
        end else if (!en_b) begin
            cnt_m = 0; ps_m = 1'b0; age = 0; acc_valid = 1'b0;
            gates_known = 1'b1; exp_hi = 1'b0; exp_lo = 1'b0;
        end else begin
            ps_m  = (cnt_b == N - 1);
            cnt_m = (cnt_b + 1) % N;
            if (cnt_b == N - 1) begin
                nd     = duty_of(s_b);
                age    = (nd == duty_m) ? age + 1 : 0;
                duty_m = nd;
            end
            gates_known = (age >= 2);
            if (gates_known) expected_gates(duty_m, cnt_m, exp_hi, exp_lo);
        end
        #1;
        observe(rst_b, en_b);
    endtask

    task automatic run_const(input logic [15:0] s, input int cycles);
        sample_in = s;
        repeat (cycles) tick();
    endtask

    // Random junk on sample_in except on the load cycle, which carries the target duty.
    task automatic run_duty(input int d, input int periods);
        repeat (periods * N) begin
            sample_in = (cnt_m == N - 1) ? sample_for(d) : 16'($urandom);
            tick();
        end
    endtask

    initial begin
        int bounds[9] = '{0, 1, 4, 5, 127, 251, 252, 254, 255};
        int t;
        int step;

        reset     = 1'b1;
        enable    = 1'b1;
        sample_in = 16'h0000;
        repeat (3) tick();
        reset = 1'b0;

        run_const(16'h0000, 4 * N);
        run_const(16'h8000, 4 * N);
        run_const(16'h7FFF, 4 * N);

        // Mid-period sample change from mid-scale
        run_const(16'h0000, 3 * N);
        for (int i = 0; i < N && cnt_m != 50; i++) tick();
        check("cnt_at_50_duty", 32'(duty_out), 32'd128);
        run_const(16'h4000, 4 * N);

        // Enable drop during HIGH, then re-enable
        run_const(16'h0000, 4 * N);
        for (int i = 0; i < N && cnt_m != 60; i++) tick();
        check("hi_before_drop", 32'(pwm_hi), 32'd1);
        enable = 1'b0;
        tick();
        repeat (5) tick();
        enable = 1'b1;
        for (int i = 0; i < DT; i++) begin
            tick();
            check("reenable_dead_hi", 32'(pwm_hi), 32'd0);
            check("reenable_dead_lo", 32'(pwm_lo), 32'd0);
        end
        tick();
        check("reenable_first_hi", 32'(pwm_hi), 32'd1);

        foreach (bounds[i]) run_duty(bounds[i], 4);
        repeat (6) run_duty(int'($urandom_range(0, N - 1)), 4);

        // Reset mid-operation
        for (int i = 0; i < 100; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_duty(200, 4);

        // Triangular source: only duty tracking and the overlap invariant apply
        t    = -32768;
        step = 1024;
        repeat (4 * N) begin
            sample_in = 16'(t);
            if (t + step > 32767 || t + step < -32768) step = -step;
            t += step;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pwm_modulator.md
# pwm_modulator

Converts the 16-bit two's-complement waveform samples produced by the DDS wave generators (triangular, sine, and so on) into a centre-free, edge-aligned PWM pair for the half-bridge output stage. The block sits directly downstream of the wave generator. Once per PWM period it samples that generator's free-running output and maps it to an offset-binary duty value. It then drives complementary high-side and low-side gates with programmable dead-time.

## Interface
- CNT_W, 10: PWM counter width; PWM period = 2^CNT_W clk cycles; legal range 4..16.
- DEADTIME, 8: both-gates-off interval, in clk cycles, inserted on every gate transition; legal range 1..255.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  modulator run; low forces both gates off.
- sample_in  in  16  signed two's-complement waveform sample; may change every cycle.
- pwm_hi  out  1  high-side gate drive.
- pwm_lo  out  1  low-side gate drive.
- period_start  out  1  one-cycle pulse marking the cycle in which the counter is 0.
- duty_out  out  CNT_W  duty value currently in effect (debug/monitor).

## Operation
- Offset conversion: u = sample_in with bit 15 inverted, so 0x8000 maps to 0 and 0x7FFF maps to 0xFFFF. duty_next = u[15:16-CNT_W], i.e. truncation with no rounding.
- Period counter cnt (CNT_W bits):
  - When enable=1, cnt increments every cycle and wraps from 2^CNT_W-1 to 0.
  - When enable=0, cnt is held at 0.
- Duty register: loaded with duty_next only on cycles where enable=1 and cnt = 2^CNT_W-1. The new value is in effect from the following cnt=0. sample_in is ignored at all other times.
- Raw compare: raw = (cnt < duty_reg), unsigned.
  - duty 0 gives raw constantly 0.
  - Maximum duty gives raw low for exactly one cycle per period; 100% duty is not reachable.
- Gate FSM (registered outputs), with states IDLE, DEAD, HIGH, LOW:
  - IDLE: pwm_hi=pwm_lo=0. When enable=1, go to DEAD.
  - DEAD: pwm_hi=pwm_lo=0; the dead counter is loaded with DEADTIME on entry. It stays in DEAD for exactly DEADTIME cycles. On exit it goes to HIGH if raw=1 in the final DEAD cycle, otherwise to LOW.
  - HIGH: pwm_hi=1, pwm_lo=0. If raw=0, go to DEAD.
  - LOW: pwm_hi=0, pwm_lo=1. If raw=1, go to DEAD.
  - A raw change during DEAD does not restart the dead counter; the exit decision alone uses raw. A raw pulse shorter than DEADTIME may therefore be swallowed.
  - Any state with enable=0 goes to IDLE on the next edge, which has priority over all other transitions.
- Invariant: pwm_hi and pwm_lo are never both 1, in any cycle and including reset.
- period_start = registered (enable=1 and cnt=2^CNT_W-1), so it is high in exactly the cycle in which cnt=0.

## Timing
- Reset values:
  - cnt=0
  - duty_reg = duty_out = 2^(CNT_W-1), which is mid-scale (a zero signal)
  - state=IDLE, pwm_hi=0, pwm_lo=0, period_start=0
  - dead counter=0
- Reset asserted mid-operation takes effect at the next edge, regardless of enable or state.
- Gate latency: a raw change seen at edge N produces the DEAD entry (both gates low) after edge N.
- Steady state per period, with duty d where 0<d<2^CNT_W:
  - pwm_hi high for d-DEADTIME cycles and pwm_lo high for 2^CNT_W-d-DEADTIME cycles, each clamped at 0, with two DEAD gaps.
  - When one phase is shorter than or equal to DEADTIME, that gate never asserts. The period then contains one DEAD gap and the other gate is high for 2^CNT_W-DEADTIME cycles.
- Sample-to-duty latency: the sample present at the cnt=2^CNT_W-1 edge appears on duty_out one cycle later.
- Enable deassertion gives both gates low one cycle later. On re-enable, counting restarts from cnt=0 and the first gate is asserted only after DEADTIME cycles.

## Test plan
Conditions for all scenarios: CNT_W=8, DEADTIME=4, period 256.
- Reset check: hold reset for 3 cycles with enable=1 → pwm_hi=pwm_lo=0, period_start=0, duty_out=128. After reset is released, period_start pulses every 256 cycles.
- Mid-scale: sample_in=0x0000 constant → duty_out=128. Per period: pwm_hi 124 cycles, DEAD 4, pwm_lo 124 cycles, DEAD 4.
- Negative full scale: sample_in=0x8000 → duty_out=0. pwm_lo high continuously after the initial 4-cycle DEAD; pwm_hi never asserts.
- Positive full scale: sample_in=0x7FFF → duty_out=255. pwm_hi high 252 cycles, then both low for 4 cycles, every period; pwm_lo never asserts.
- Mid-period change: set sample_in to 0x4000 while cnt=50 (duty_out was 128) → duty_out stays 128 until one cycle after cnt=255. The next period shows pwm_hi for 188 cycles (duty 192).
- Enable and overlap: drop enable during HIGH → both gates low next cycle, cnt=0. Re-assert enable → 4 DEAD cycles precede the first gate. Run a checker across the whole run asserting pwm_hi&pwm_lo is never 1, including with a triangular-wave source on sample_in.
